// File: rtl/mfcc_frame_sequencer.sv
// mfcc_frame_sequencer: frame-level MFCC stage sequencer with sample credit, coefficient drain and watchdog
module mfcc_frame_sequencer #(
  parameter int NUM_COEFFICIENTS = 12,
  parameter int CEPS_WIDTH       = 16,
  parameter int FRAME_SIZE       = 400,
  parameter int FRAME_MOVE       = 160,
  parameter int PCM_FIFO_DEPTH   = 256,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                pcm_ready_i,
  input  logic                                hamming_start_i,
  input  logic                                hamming_done_i,
  input  logic                                fft_done_i,
  input  logic                                mel_done_i,
  input  logic                                dct_done_i,
  input  logic                                dct_valid_i,
  input  logic [$clog2(NUM_COEFFICIENTS)-1:0] ceps_ptr_i,
  input  logic [CEPS_WIDTH-1:0]               ceps_sample_i,
  input  logic                                clear_i,
  output logic                                start_move_o,
  output logic                                coeff_valid_o,
  input  logic                                coeff_ready_i,
  output logic [CEPS_WIDTH-1:0]               coeff_data_o,
  output logic [$clog2(NUM_COEFFICIENTS)-1:0] coeff_idx_o,
  output logic                                coeff_last_o,
  output logic                                busy_o,
  output logic                                overrun_o,
  output logic                                error_o,
  output logic [15:0]                         frame_count_o
);
  localparam int PW = $clog2(NUM_COEFFICIENTS);
  localparam int CW = $clog2(FRAME_MOVE + PCM_FIFO_DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(FRAME_MOVE + PCM_FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(NUM_COEFFICIENTS - 1);
  typedef enum logic [3:0] {
    WAIT_WIN, HAMMING, FFT, MEL, DCT, DRAIN, WAIT_CREDIT, MOVE, ERROR
  } state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic [WW-1:0]         wd_q, wd_d;
  logic [PW-1:0]         idx_q, idx_d;
  logic [15:0]           frames_q, frames_d;
  logic                  overrun_q, overrun_d, first_q, first_d, live_q, watched;
  logic [CEPS_WIDTH-1:0] buf_q [NUM_COEFFICIENTS];
  logic [CEPS_WIDTH-1:0] buf_d [NUM_COEFFICIENTS];
  assign watched = state_q inside {HAMMING, FFT, MEL, DCT};
  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    overrun_d = overrun_q;
    first_d   = first_q;
    idx_d     = idx_q;
    frames_d  = frames_q;
    buf_d     = buf_q;
    if (live_q) begin
      if (state_q != ERROR && pcm_ready_i) begin
        if (credit_q == CMAX) overrun_d = 1'b1;
        else credit_d = credit_q + 1'b1;
      end
      case (state_q)
        WAIT_WIN: if (hamming_start_i) begin
          state_d = HAMMING;
          if (first_q) begin
            credit_d = '0;
            first_d  = 1'b0;
          end
        end
        HAMMING: state_d = hamming_done_i ? FFT : state_q;
        FFT:     state_d = fft_done_i ? MEL : state_q;
        MEL:     state_d = mel_done_i ? DCT : state_q;
        DCT: begin
          if (dct_valid_i && 32'(ceps_ptr_i) < NUM_COEFFICIENTS) buf_d[ceps_ptr_i] = ceps_sample_i;
          if (dct_done_i) begin
            state_d = DRAIN;
            idx_d   = '0;
          end
        end
        DRAIN: if (coeff_ready_i) begin
          idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_d  = WAIT_CREDIT;
            frames_d = frames_q + 1'b1;
          end
        end
        WAIT_CREDIT: state_d = (32'(credit_q) >= FRAME_MOVE) ? MOVE : state_q;
        MOVE: begin
          state_d  = WAIT_WIN;
          credit_d = credit_q + CW'(pcm_ready_i) - CW'(FRAME_MOVE);
        end
        default: ;
      endcase
      if (watched && state_d == state_q && wd_q == WW'(TIMEOUT_CYCLES - 1)) state_d = ERROR;
      if (clear_i) begin
        state_d   = WAIT_WIN;
        credit_d  = '0;
        overrun_d = 1'b0;
        idx_d     = '0;
        first_d   = 1'b1;
      end
    end
    wd_d = (watched && state_d == state_q) ? wd_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_WIN;
      credit_q  <= '0;
      wd_q      <= '0;
      idx_q     <= '0;
      frames_q  <= '0;
      overrun_q <= 1'b0;
      first_q   <= 1'b1;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      wd_q      <= wd_d;
      idx_q     <= idx_d;
      frames_q  <= frames_d;
      overrun_q <= overrun_d;
      first_q   <= first_d;
      live_q    <= 1'b1;
    end
  end
  always_ff @(posedge clk) buf_q <= buf_d;
  assign start_move_o  = state_q == MOVE;
  assign coeff_valid_o = state_q == DRAIN;
  assign coeff_data_o  = coeff_valid_o ? buf_q[idx_q] : '0;
  assign coeff_idx_o   = idx_q;
  assign coeff_last_o  = coeff_valid_o && idx_q == LAST;
  assign busy_o        = !(state_q inside {WAIT_WIN, WAIT_CREDIT, ERROR});
  assign overrun_o     = overrun_q;
  assign error_o       = state_q == ERROR;
  assign frame_count_o = frames_q;
endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// tb_mfcc_frame_sequencer: directed self-checking bench for mfcc_frame_sequencer
module tb_mfcc_frame_sequencer;
  localparam int S_WAIT_WIN = 0, S_HAMMING = 1, S_FFT = 2, S_MEL = 3, S_DCT = 4;
  localparam int S_DRAIN = 5, S_WAIT_CREDIT = 6, S_MOVE = 7, S_ERROR = 8;
  logic clk = 0, rst_n = 0;
  logic pcm_ready_i = 0, hamming_start_i = 0, hamming_done_i = 0, fft_done_i = 0;
  logic mel_done_i = 0, dct_done_i = 0, dct_valid_i = 0, clear_i = 0, coeff_ready_i = 0;
  logic [3:0] ceps_ptr_i = 0, coeff_idx_o;
  logic [15:0] ceps_sample_i = 0, coeff_data_o, frame_count_o;
  logic start_move_o, coeff_valid_o, coeff_last_o, busy_o, overrun_o, error_o;
  int errors = 0, checks = 0;
  logic seen;
  mfcc_frame_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .pcm_ready_i(pcm_ready_i), .hamming_start_i(hamming_start_i),
    .hamming_done_i(hamming_done_i), .fft_done_i(fft_done_i), .mel_done_i(mel_done_i),
    .dct_done_i(dct_done_i), .dct_valid_i(dct_valid_i), .ceps_ptr_i(ceps_ptr_i),
    .ceps_sample_i(ceps_sample_i), .clear_i(clear_i), .start_move_o(start_move_o),
    .coeff_valid_o(coeff_valid_o), .coeff_ready_i(coeff_ready_i), .coeff_data_o(coeff_data_o),
    .coeff_idx_o(coeff_idx_o), .coeff_last_o(coeff_last_o), .busy_o(busy_o),
    .overrun_o(overrun_o), .error_o(error_o), .frame_count_o(frame_count_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input int s);
    hamming_start_i = s == 0;
    hamming_done_i  = s == 1;
    fft_done_i      = s == 2;
    mel_done_i      = s == 3;
    dct_done_i      = s == 4;
    clear_i         = s == 5;
    tick(1);
    {hamming_start_i, hamming_done_i, fft_done_i, mel_done_i, dct_done_i, clear_i} = '0;
  endtask
  initial begin
    tick(2);
    chk("rst_state", 32'(dut.state_q), S_WAIT_WIN);
    chk("rst_outs", {start_move_o, coeff_valid_o, coeff_last_o, busy_o, overrun_o, error_o}, 0);
    chk("rst_frames", frame_count_o, 0);
    chk("rst_data", coeff_data_o, 0);
    rst_n = 1;
    tick(2);
    pulse(0);
    chk("ham_state", 32'(dut.state_q), S_HAMMING);
    chk("ham_busy", busy_o, 1);
    pulse(2);
    chk("fft_done_ignored", 32'(dut.state_q), S_HAMMING);
    pulse(1);
    chk("fft_state", 32'(dut.state_q), S_FFT);
    pulse(2);
    pulse(3);
    chk("dct_state", 32'(dut.state_q), S_DCT);
    for (int i = 0; i < 12; i++) begin
      dct_valid_i = 1; ceps_ptr_i = 4'(i); ceps_sample_i = 16'(16'h100 + i); dct_done_i = i == 11;
      tick(1);
    end
    dct_valid_i = 0; dct_done_i = 0;
    chk("drain_state", 32'(dut.state_q), S_DRAIN);
    coeff_ready_i = 1;
    for (int i = 0; i < 12; i++) begin
      chk("beat_valid", coeff_valid_o, 1);
      chk("beat_idx", coeff_idx_o, i);
      chk("beat_data", coeff_data_o, 16'h100 + i);
      chk("beat_last", coeff_last_o, i == 11);
      if (i == 5) begin
        coeff_ready_i = 0;
        tick(20);
        chk("hold_data", coeff_data_o, 16'h105);
        chk("hold_idx", coeff_idx_o, 5);
        chk("hold_valid", coeff_valid_o, 1);
        coeff_ready_i = 1;
      end
      tick(1);
    end
    coeff_ready_i = 0;
    chk("drain_done_valid", coeff_valid_o, 0);
    chk("frames_1", frame_count_o, 1);
    chk("wait_credit_state", 32'(dut.state_q), S_WAIT_CREDIT);
    seen = 0;
    pcm_ready_i = 1;
    for (int i = 0; i < 159; i++) begin
      tick(1);
      seen |= start_move_o;
    end
    pcm_ready_i = 0;
    tick(3);
    seen |= start_move_o;
    chk("no_move_159", seen, 0);
    chk("credit_159", 32'(dut.credit_q), 159);
    pcm_ready_i = 1;
    tick(1);
    pcm_ready_i = 0;
    chk("credit_160", 32'(dut.credit_q), 160);
    chk("move_not_yet", start_move_o, 0);
    tick(1);
    chk("move_pulse", start_move_o, 1);
    chk("move_state", 32'(dut.state_q), S_MOVE);
    tick(1);
    chk("move_once", start_move_o, 0);
    chk("after_move_state", 32'(dut.state_q), S_WAIT_WIN);
    chk("credit_zero", 32'(dut.credit_q), 0);
    pcm_ready_i = 1;
    tick(416);
    chk("credit_416", 32'(dut.credit_q), 416);
    chk("no_overrun_416", overrun_o, 0);
    tick(1);
    chk("overrun_417", overrun_o, 1);
    chk("credit_sat", 32'(dut.credit_q), 416);
    tick(3);
    pcm_ready_i = 0;
    chk("credit_sat_420", 32'(dut.credit_q), 416);
    chk("overrun_sticky", overrun_o, 1);
    pulse(5);
    chk("clear_overrun", overrun_o, 0);
    chk("clear_credit", 32'(dut.credit_q), 0);
    chk("clear_frames_kept", frame_count_o, 1);
    pulse(0);
    pulse(1);
    chk("wd_fft", 32'(dut.state_q), S_FFT);
    tick(99);
    chk("wd_99", error_o, 0);
    tick(1);
    chk("wd_100", error_o, 1);
    chk("err_state", 32'(dut.state_q), S_ERROR);
    chk("err_busy", busy_o, 0);
    chk("err_valid", coeff_valid_o, 0);
    pulse(2);
    chk("err_fft_ignored", 32'(dut.state_q), S_ERROR);
    pcm_ready_i = 1;
    tick(2);
    pcm_ready_i = 0;
    chk("err_no_credit", 32'(dut.credit_q), 0);
    chk("err_no_move", start_move_o, 0);
    pulse(5);
    chk("clear_error", error_o, 0);
    chk("clear_state", 32'(dut.state_q), S_WAIT_WIN);
    pulse(0); pulse(1); pulse(2); pulse(3); pulse(4);
    chk("drain2_valid", coeff_valid_o, 1);
    chk("drain2_data", coeff_data_o, 16'h100);
    #2 rst_n = 0;
    #1;
    chk("async_valid", coeff_valid_o, 0);
    chk("async_frames", frame_count_o, 0);
    chk("async_state", 32'(dut.state_q), S_WAIT_WIN);
    tick(1);
    rst_n = 1;
    tick(2);
    chk("post_rst_state", 32'(dut.state_q), S_WAIT_WIN);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
